// File: rtl/int_gateway_if.sv
// AXI4-Lite register port of the interrupt gateway (12-bit address, 32-bit data).
interface int_gateway_if;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/int_gateway.sv
// Interrupt gateway: sync + polarity/edge-level per source, one-cycle request pulse, hold in WAIT until completion.
// Pulse nsync+1 cycles after first sample; AXI one write/read in flight each. INTGW_TIMEOUT_EN adds WAIT timeout.
module int_gateway #(
    parameter int ndev  = 8,
    parameter int nsync = 2,
    parameter int tmo_w = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ndev-1:0]         irq_src,
    output logic [ndev-1:0]         int_vect,
    input  logic                    cmpl_valid,
    input  logic [$clog2(ndev)-1:0] cmpl_id,
    int_gateway_if.slave            s_axi
);
    localparam logic [ndev-1:0] src_mask = {{(ndev-1){1'b1}}, 1'b0};
    localparam logic [9:0] A_MODE  = 10'd0;
    localparam logic [9:0] A_POL   = 10'd1;
    localparam logic [9:0] A_INFL  = 10'd2;
    localparam logic [9:0] A_EPEND = 10'd3;
    localparam logic [9:0] A_TMO   = 10'd4;
    localparam logic [9:0] A_TSTAT = 10'd5;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          st [ndev];
    state_t          st_nx [ndev];
    logic [ndev-1:0] sync_q [nsync];
    logic [ndev-1:0] mode, pol, edge_pend, pend_nx, vect_nx;
    logic [ndev-1:0] act, act_q, rise, req, inflight, cmpl_hit, inf_clr, tmo_hit;

    logic        aw_full, w_full, bvalid_q, wr_commit;
    logic [9:0]  aw_idx;
    logic [31:0] w_dat;
    logic        ar_full, rvalid_q;
    logic [9:0]  ar_idx;
    logic [31:0] rdata_q, rd_val;
    logic        unused_bits;

    // ---------------- synchronizer and request shaping ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < nsync; j++) sync_q[j] <= '0;
            act_q <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int j = 1; j < nsync; j++) sync_q[j] <= sync_q[j-1];
            act_q <= act;
        end
    end

    assign act  = sync_q[nsync-1] ^ pol;
    assign rise = act & ~act_q;
    assign req  = ((mode & (edge_pend | rise)) | (~mode & act)) & src_mask;

    always_comb begin
        cmpl_hit = '0;
        inflight = '0;
        for (int i = 1; i < ndev; i++) begin
            cmpl_hit[i] = cmpl_valid && (int'(cmpl_id) == i);
            inflight[i] = (st[i] == S_WAIT);
        end
    end

    assign inf_clr = (wr_commit && aw_idx == A_INFL) ? (w_dat[ndev-1:0] & src_mask) : '0;

    // ---------------- per-source IDLE/WAIT machine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ndev; i++) st[i] <= S_IDLE;
            edge_pend <= '0;
            int_vect  <= '0;
        end else begin
            for (int i = 0; i < ndev; i++) st[i] <= st_nx[i];
            edge_pend <= pend_nx;
            int_vect  <= vect_nx;
        end
    end

    always_comb begin
        st_nx   = st;
        pend_nx = edge_pend;
        vect_nx = '0;
        for (int i = 1; i < ndev; i++) begin
            case (st[i])
                S_IDLE: begin
                    if (req[i]) begin
                        vect_nx[i] = 1'b1;
                        st_nx[i]   = S_WAIT;
                        pend_nx[i] = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mode[i] && rise[i]) pend_nx[i] = 1'b1;
                    if (cmpl_hit[i] || inf_clr[i] || tmo_hit[i]) st_nx[i] = S_IDLE;
                end
                default: st_nx[i] = S_IDLE;
            endcase
            // a pending edge is meaningless once the source is level-triggered
            if (!mode[i]) pend_nx[i] = 1'b0;
        end
    end

`ifdef INTGW_TIMEOUT_EN
    localparam logic [tmo_w-1:0] tmo_one = {{(tmo_w-1){1'b0}}, 1'b1};
    logic [tmo_w-1:0] tmo_reg;
    logic [tmo_w-1:0] tcnt [ndev];
    logic [ndev-1:0]  tmostat;

    always_comb begin
        tmo_hit = '0;
        for (int i = 1; i < ndev; i++)
            tmo_hit[i] = (st[i] == S_WAIT) && (tmo_reg != '0) && (tcnt[i] == tmo_reg - tmo_one);
    end

    // counter holds 0 while idle, so the first WAIT cycle counts from 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ndev; i++) tcnt[i] <= '0;
            tmo_reg <= '0;
            tmostat <= '0;
        end else begin
            for (int i = 0; i < ndev; i++) tcnt[i] <= (st[i] == S_WAIT) ? tcnt[i] + tmo_one : '0;
            if (wr_commit && aw_idx == A_TMO) tmo_reg <= w_dat[tmo_w-1:0];
            if (wr_commit && aw_idx == A_TSTAT)
                tmostat <= (tmostat & ~(w_dat[ndev-1:0] & src_mask)) | tmo_hit;
            else
                tmostat <= tmostat | tmo_hit;
        end
    end
`else
    assign tmo_hit = '0;
`endif

    // ---------------- AXI write channel ----------------
    assign s_axi.awready = !aw_full;
    assign s_axi.wready  = !w_full;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign wr_commit     = aw_full && w_full && !bvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b0;
            aw_idx   <= '0;
            w_dat    <= '0;
            mode     <= '0;
            pol      <= '0;
        end else begin
            if (s_axi.awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi.awaddr[11:2];
            end
            if (s_axi.wvalid && !w_full) begin
                w_full <= 1'b1;
                w_dat  <= s_axi.wdata;
            end
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                if (aw_idx == A_MODE) mode <= w_dat[ndev-1:0] & src_mask;
                if (aw_idx == A_POL)  pol  <= w_dat[ndev-1:0] & src_mask;
            end
            if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
            end
        end
    end

    // ---------------- AXI read channel ----------------
    assign s_axi.arready = !ar_full;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    always_comb begin
        rd_val = '0;
        case (ar_idx)
            A_MODE:  rd_val[ndev-1:0] = mode;
            A_POL:   rd_val[ndev-1:0] = pol;
            A_INFL:  rd_val[ndev-1:0] = inflight;
            A_EPEND: rd_val[ndev-1:0] = edge_pend;
`ifdef INTGW_TIMEOUT_EN
            A_TMO:   rd_val[tmo_w-1:0] = tmo_reg;
            A_TSTAT: rd_val[ndev-1:0]  = tmostat;
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_full  <= 1'b0;
            ar_idx   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (s_axi.arvalid && !ar_full) begin
                ar_full <= 1'b1;
                ar_idx  <= s_axi.araddr[11:2];
            end
            if (ar_full && !rvalid_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end
            if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
                ar_full  <= 1'b0;
            end
        end
    end

    assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], w_dat};
endmodule

// File: tb/tb_int_gateway.sv
// Scoreboard bench for int_gateway: stimulus queues expected pulses / read data, a negedge monitor checks them.
module tb_int_gateway;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_src;
    logic [7:0] int_vect;
    logic       cmpl_valid;
    logic [2:0] cmpl_id;

    int_gateway_if axi();

    int_gateway #(.ndev(8), .nsync(2), .tmo_w(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .int_vect   (int_vect),
        .cmpl_valid (cmpl_valid),
        .cmpl_id    (cmpl_id),
        .s_axi      (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  pq_vec[$];
    int          pq_cyc[$];
    logic [31:0] rq_dat[$];
    int          rq_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // monitor: every pulse and every read beat must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (int_vect !== 8'h00) begin
                if (pq_vec.size() == 0) chk("unexpected_pulse", int_vect, 0);
                else begin
                    chk("pulse_vec", int_vect, pq_vec.pop_front());
                    chk("pulse_cyc", cyc, pq_cyc.pop_front());
                end
            end
            if (axi.rvalid) begin
                if (rq_dat.size() == 0) chk("unexpected_rvalid", axi.rvalid, 0);
                else begin
                    chk("rdata", axi.rdata, rq_dat.pop_front());
                    chk("rvalid_cyc", cyc, rq_cyc.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [7:0] v, input int c);
        pq_vec.push_back(v);
        pq_cyc.push_back(c);
    endtask

    task automatic complete(input logic [2:0] id);
        cmpl_id    = id;
        cmpl_valid = 1'b1;
        tick(1);
        cmpl_valid = 1'b0;
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input int wdly, output int bcyc);
        bit aw_done, w_done, aw_hs, w_hs;
        int t, wcap;
        aw_done = 0; w_done = 0; t = 0; wcap = 0;
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        while (!(aw_done && w_done) && t < 40) begin
            if (t == wdly) begin
                axi.wdata  = data;
                axi.wvalid = 1'b1;
            end
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            if (wdly > 0 && aw_done && !w_done) chk("awready_held_low", axi.awready, 0);
            @(posedge clk); #1;
            if (aw_hs) begin axi.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin axi.wvalid = 1'b0; w_done = 1; wcap = cyc; end
            t++;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        t = 0;
        @(negedge clk);
        while (!axi.bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bvalid_latency", cyc - wcap, 1);
        bcyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp);
        bit hs;
        int t;
        hs = 0; t = 0;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        while (!hs && t < 20) begin
            @(negedge clk);
            hs = axi.arready;
            @(posedge clk); #1;
            t++;
        end
        axi.arvalid = 1'b0;
        chk("ar_handshake", hs, 1);
        if (hs) begin
            rq_dat.push_back(exp);
            rq_cyc.push_back(cyc + 1);
        end
        t = 0;
        while (rq_dat.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("read_drain", rq_dat.size(), 0);
    endtask

    initial begin
        int d, n, b;
        rst = 1'b1; irq_src = '0; cmpl_valid = 1'b0; cmpl_id = '0;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
        chk("rst_valid", {axi.bvalid, axi.rvalid}, 2'b00);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_int_vect", int_vect, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // level source 3: pulse 3 cycles after drive, re-pulse 2 after completion
        d = cyc; irq_src[3] = 1'b1; expect_pulse(8'h08, d + 3);
        tick(6);
        axi_read(12'h008, 32'h08);
        n = cyc; expect_pulse(8'h08, n + 2);
        complete(3'd3);
        tick(3); irq_src[3] = 1'b0; tick(4);
        complete(3'd3);
        tick(3);
        axi_read(12'h008, 32'h00);

        // completions for id 0 and for idle source 7 leave source 3 in WAIT
        d = cyc; irq_src[3] = 1'b1; expect_pulse(8'h08, d + 3);
        tick(6); irq_src[3] = 1'b0; tick(3);
        complete(3'd0);
        complete(3'd7);
        tick(2);
        axi_read(12'h008, 32'h08);
        complete(3'd3);
        tick(3);
        axi_read(12'h008, 32'h00);

        // edge mode source 5: edges during WAIT coalesce into one pending pulse
        axi_write(12'h000, 32'h20, 0, b);
        d = cyc; irq_src[5] = 1'b1; expect_pulse(8'h20, d + 3);
        tick(2); irq_src[5] = 1'b0; tick(2);
        for (int k = 0; k < 3; k++) begin
            irq_src[5] = 1'b1; tick(2);
            irq_src[5] = 1'b0; tick(2);
        end
        tick(3);
        axi_read(12'h00C, 32'h20);
        axi_read(12'h008, 32'h20);
        n = cyc; expect_pulse(8'h20, n + 2);
        complete(3'd5);
        tick(4);
        axi_read(12'h00C, 32'h00);
        complete(3'd5);
        tick(3);
        axi_read(12'h008, 32'h00);
        axi_write(12'h000, 32'h00, 0, b);

        // polarity: active-low source 2 with line idle low fires right after the write
        axi_write(12'h004, 32'h04, 0, b);
        expect_pulse(8'h04, b + 1);
        tick(2);
        axi_read(12'h008, 32'h04);
        axi_write(12'h004, 32'h00, 0, b);
        tick(3);
        axi_read(12'h008, 32'h04);
        axi_write(12'h008, 32'h04, 0, b);
        tick(2);
        axi_read(12'h008, 32'h00);

        // AXI corner cases: late W, masked bits, unmapped offset
        axi_write(12'h000, 32'hFFFF_FFFF, 3, b);
        axi_read(12'h000, 32'hFE);
        axi_write(12'h000, 32'h00, 0, b);
        axi_read(12'h000, 32'h00);
        axi_write(12'h004, 32'hFFFF_FF00, 0, b);
        axi_read(12'h004, 32'h00);
        axi_write(12'h03C, 32'h0000_FFFF, 0, b);
        axi_read(12'h03C, 32'h00);

`ifdef INTGW_TIMEOUT_EN
        axi_write(12'h010, 32'd10, 0, b);
        axi_read(12'h010, 32'd10);
        d = cyc; irq_src[1] = 1'b1;
        expect_pulse(8'h02, d + 3);
        expect_pulse(8'h02, d + 14);
        tick(15); irq_src[1] = 1'b0; tick(20);
        axi_read(12'h014, 32'h02);
        axi_read(12'h008, 32'h00);
        axi_write(12'h014, 32'h02, 0, b);
        axi_read(12'h014, 32'h00);
`else
        axi_write(12'h010, 32'd10, 0, b);
        axi_read(12'h010, 32'h00);
        axi_read(12'h014, 32'h00);
        d = cyc; irq_src[1] = 1'b1; expect_pulse(8'h02, d + 3);
        tick(15); irq_src[1] = 1'b0; tick(10);
        axi_read(12'h008, 32'h02);
        complete(3'd1);
        tick(3);
        axi_read(12'h008, 32'h00);
`endif

        tick(5);
        chk("pulse_queue_empty", pq_vec.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
